get_sched: RTL and testbench
============================

// Module: get_sched
// PURPOSE
//  Phase sequencer for the input get-stream. After a start pulse it first
//  routes N beats to matrix-write (matw phase), then K beats to compute
//  (run phase), then drains the downstream pipeline and pulses done.
//  Owns get_ready: backpressure comes from a downstream stall.
//  Sits between the host stream source and the get-side datapath/matrix store.
// PARAMETERS
//  MAT_W      10  width of mat_len / mat_addr (matrix depth up to 2**MAT_W-1 words)
//  RUN_W      16  width of run_len / run_idx
//  DRAIN_LAT   4  cycles spent in DRAIN before done (0 = skip DRAIN)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      1-cycle request; sampled only in IDLE
//  mat_len      in   MAT_W  matrix words to accept; latched at start
//  run_len      in   RUN_W  data words to accept; latched at start
//  get_valid    in   1      source has a beat
//  stall        in   1      downstream backpressure
//  get_ready    out  1      block accepts a beat this cycle
//  matw         out  1      registered; high while state==MATW
//  run          out  1      registered; high while state==RUN
//  mat_we       out  1      beat accepted in MATW (comb)
//  mat_addr     out  MAT_W  write address of current MATW beat, 0..mat_len-1
//  get_v        out  1      beat accepted in RUN (comb)
//  run_idx      out  RUN_W  index of current RUN beat, 0..run_len-1
//  busy         out  1      state != IDLE
//  done         out  1      1-cycle pulse on sequence completion
// BEHAVIOUR
//  - States: IDLE, MATW, RUN, DRAIN, DONE. Reset -> IDLE.
//  - All outputs are 0 in reset and IDLE; counters are cleared to 0.
//  - get_ready = (MATW|RUN) & ~stall, combinational; never asserted in IDLE/DRAIN/DONE.
//  - beat = get_valid & get_ready.
//  - mat_we = beat & MATW; get_v = beat & RUN; both combinational, same cycle.
//  - mat_addr / run_idx: registered; increment on each beat.
//  - IDLE + start: latch lengths; next state is MATW if mat_len!=0,
//    else RUN if run_len!=0, else DRAIN (DONE if DRAIN_LAT==0).
//  - MATW: beat at mat_addr==mat_len-1 -> RUN (or DRAIN/DONE if run_len==0).
//  - RUN: beat at run_idx==run_len-1 -> DRAIN (DONE if DRAIN_LAT==0).
//  - DRAIN: down-counter loaded with DRAIN_LAT-1; -> DONE at 0. Ignores stall.
//  - DONE: done=1 for exactly one cycle -> IDLE. start in the DONE cycle is ignored.
//  - start while busy: ignored. Input changes after start are ignored.
//  - stall or ~get_valid holds the state and counters. No timeout.
//  - A beat on the last index with stall low transitions that cycle.
//    Exactly mat_len + run_len beats are accepted per sequence.
//  - rst_n low mid-sequence: immediate return to IDLE, outputs 0,
//    no done pulse; accepted beats are not replayed.
// CONFIGURATION
//  GET_SCHED_PERF_EN defined: adds output stall_cyc[31:0], registered.
//    - Cleared on start.
//    - +1 each cycle in MATW|RUN with ~beat (valid low or stall high).
//    - Saturates at 32'hFFFF_FFFF. Held after done; reset to 0.
//  Not defined: the port and the counter are absent; behaviour is otherwise identical.
// TESTING
//  1 mat_len=3, run_len=5, valid=1, stall=0, start@T0
//    -> mat_we T1..T3 (addr 0,1,2); get_v T4..T8 (idx 0..4);
//       DRAIN T9..T12; done=1 only at T13; busy T1..T13.
//  2 mat_len=0, run_len=2 -> matw never high; get_v at T1,T2; done at T7.
//  3 mat_len=2, run_len=2, stall=1 during T2..T4
//    -> get_ready=0 T2..T4; 4 beats total; done delayed 3 cycles vs. no stall;
//       perf build stall_cyc=3.
//  4 start pulses repeated while busy; mat_len/run_len changed mid-run
//    -> ignored, single done, beat counts match the latched lengths.
//  5 rst_n low while in RUN (run_idx=2) -> same cycle all outputs 0,
//    state IDLE, no done; new start restarts from mat_addr=0.
//  6 mat_len=0, run_len=0, DRAIN_LAT=0 -> get_ready never 1; done at T1.

Source files
------------

// File: rtl/get_sched.sv
// get_sched: phase sequencer for the input get-stream.
// After a start pulse it routes mat_len beats to matrix-write (MATW),
// then run_len beats to compute (RUN), waits DRAIN_LAT cycles for the
// downstream pipeline to empty (DRAIN) and pulses done for one cycle.
// Optional feature macro: GET_SCHED_PERF_EN adds the stall_cyc counter.
module get_sched #(
    parameter int MAT_W     = 10,
    parameter int RUN_W     = 16,
    parameter int DRAIN_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MAT_W-1:0] mat_len,
    input  logic [RUN_W-1:0] run_len,
    input  logic             get_valid,
    input  logic             stall,
    output logic             get_ready,
    output logic             matw,
    output logic             run,
    output logic             mat_we,
    output logic [MAT_W-1:0] mat_addr,
    output logic             get_v,
    output logic [RUN_W-1:0] run_idx,
    output logic             busy,
`ifdef GET_SCHED_PERF_EN
    output logic [31:0]      stall_cyc,
`endif
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MATW,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Drain counter only needs to hold DRAIN_LAT-1.
    localparam int DW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_LAT > 0) ? DRAIN_LAT - 1 : 0);
    // Where the sequence goes once all data beats are consumed.
    localparam state_t AFTER_DATA = (DRAIN_LAT == 0) ? S_DONE : S_DRAIN;

    state_t           state_q, state_d;
    logic [MAT_W-1:0] mat_len_q, mat_len_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic [MAT_W-1:0] mat_addr_q, mat_addr_d;
    logic [RUN_W-1:0] run_idx_q, run_idx_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             matw_q, run_q, busy_q, done_q;
    logic             in_phase;
    logic             beat;
    logic             mat_last;
    logic             run_last;

    // Handshake and same-cycle beat strobes, decoded from the current state.
    always_comb begin
        in_phase  = (state_q == S_MATW) || (state_q == S_RUN);
        get_ready = in_phase & ~stall;
        beat      = get_valid & get_ready;
        mat_we    = beat & (state_q == S_MATW);
        get_v     = beat & (state_q == S_RUN);
        mat_last  = (mat_addr_q == (mat_len_q - MAT_W'(1)));
        run_last  = (run_idx_q == (run_len_q - RUN_W'(1)));
    end

    // Next-state and counter logic; stalls simply leave everything as-is.
    always_comb begin
        state_d     = state_q;
        mat_len_d   = mat_len_q;
        run_len_d   = run_len_q;
        mat_addr_d  = mat_addr_q;
        run_idx_d   = run_idx_q;
        // Count down while draining, otherwise keep it primed for entry.
        drain_cnt_d = (state_q == S_DRAIN) ? (drain_cnt_q - DW'(1)) : DRAIN_LOAD;
        case (state_q)
            S_IDLE: begin
                mat_addr_d = '0;
                run_idx_d  = '0;
                if (start) begin
                    mat_len_d = mat_len;
                    run_len_d = run_len;
                    if (mat_len != '0)      state_d = S_MATW;
                    else if (run_len != '0) state_d = S_RUN;
                    else                    state_d = AFTER_DATA;
                end
            end
            S_MATW: begin
                if (mat_we) begin
                    if (mat_last) begin
                        mat_addr_d = '0;
                        state_d    = (run_len_q != '0) ? S_RUN : AFTER_DATA;
                    end else begin
                        mat_addr_d = mat_addr_q + MAT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (get_v) begin
                    if (run_last) begin
                        run_idx_d = '0;
                        state_d   = AFTER_DATA;
                    end else begin
                        run_idx_d = run_idx_q + RUN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered phase flags; reset returns to IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mat_len_q   <= '0;
            run_len_q   <= '0;
            mat_addr_q  <= '0;
            run_idx_q   <= '0;
            drain_cnt_q <= '0;
            matw_q      <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mat_len_q   <= mat_len_d;
            run_len_q   <= run_len_d;
            mat_addr_q  <= mat_addr_d;
            run_idx_q   <= run_idx_d;
            drain_cnt_q <= drain_cnt_d;
            matw_q      <= (state_d == S_MATW);
            run_q       <= (state_d == S_RUN);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign matw     = matw_q;
    assign run      = run_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign mat_addr = mat_addr_q;
    assign run_idx  = run_idx_q;

`ifdef GET_SCHED_PERF_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;

    // Count data-phase cycles that moved no beat; saturating, cleared on start.
    always_comb begin
        stall_cyc_d = stall_cyc_q;
        if ((state_q == S_IDLE) && start)
            stall_cyc_d = '0;
        else if (in_phase && !beat && (stall_cyc_q != 32'hFFFF_FFFF))
            stall_cyc_d = stall_cyc_q + 32'd1;
    end

    // Performance counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cyc_q <= '0;
        else        stall_cyc_q <= stall_cyc_d;
    end

    assign stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_get_sched.sv
// tb_get_sched: table-driven sequences against two instances of get_sched
// (DRAIN_LAT=4 and DRAIN_LAT=0) plus hand-written reset sequences.
// Expected beats are pushed to per-instance queues when start is driven
// and popped as the DUTs report mat_we / get_v.
module tb_get_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start0;
    logic [9:0]  mat_len;
    logic [15:0] run_len;
    logic        get_valid, stall;

    logic        gr4, matw4, run4, mwe4, gv4, busy4, done4;
    logic [9:0]  addr4;
    logic [15:0] idx4;
    logic        gr0, matw0, run0, mwe0, gv0, busy0, done0;
    logic [9:0]  addr0;
    logic [15:0] idx0;
`ifdef GET_SCHED_PERF_EN
    logic [31:0] sc4, sc0;
`endif

    always #5 clk = ~clk;

    get_sched #(.MAT_W(10), .RUN_W(16), .DRAIN_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mat_len(mat_len), .run_len(run_len),
        .get_valid(get_valid), .stall(stall), .get_ready(gr4), .matw(matw4), .run(run4),
        .mat_we(mwe4), .mat_addr(addr4), .get_v(gv4), .run_idx(idx4), .busy(busy4),
`ifdef GET_SCHED_PERF_EN
        .stall_cyc(sc4),
`endif
        .done(done4)
    );

    get_sched #(.MAT_W(10), .RUN_W(16), .DRAIN_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mat_len(mat_len), .run_len(run_len),
        .get_valid(get_valid), .stall(stall), .get_ready(gr0), .matw(matw0), .run(run0),
        .mat_we(mwe0), .mat_addr(addr0), .get_v(gv0), .run_idx(idx0), .busy(busy0),
`ifdef GET_SCHED_PERF_EN
        .stall_cyc(sc0),
`endif
        .done(done0)
    );

    typedef struct {
        int ml;     // mat_len
        int rl;     // run_len
        int slo;    // stall high for cycles slo..shi
        int shi;
        int vlo;    // get_valid low for cycles vlo..vhi
        int vhi;
        int noise;  // repeat start / scramble lengths while busy
        int done;   // cycle of the done pulse, DRAIN_LAT=4 instance
        int perf;   // expected stall_cyc after done
    } vec_t;

    vec_t tv[9];
    int   q4[$];
    int   q0[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle checks for one instance; w selects the instance's queue.
    task automatic check_dut(input int w, input int t, input int dn, input int act_hi,
                             input logic stl, input logic gr, input logic mt, input logic rn,
                             input logic mw, input logic [9:0] ma, input logic gv,
                             input logic [15:0] ri, input logic bz, input logic dq);
        string tag;
        int    got;
        int    exp;
        tag = $sformatf("dut%0d t=%0d", w, t);
        chk({tag, " get_ready"}, int'(gr), int'((t >= 1) && (t <= act_hi) && !stl));
        chk({tag, " busy"}, int'(bz), int'((t >= 1) && (t <= dn)));
        chk({tag, " done"}, int'(dq), int'(t == dn));
        if (mw) chk({tag, " matw_with_we"}, int'(mt), 1);
        if (gv) chk({tag, " run_with_getv"}, int'(rn), 1);
        if (mw || gv) begin
            chk({tag, " single_strobe"}, int'(mw & gv), 0);
            got = gv ? ((1 << 16) | int'(ri)) : int'(ma);
            if (w == 4) begin
                chk({tag, " beat_expected"}, int'(q4.size() != 0), 1);
                exp = (q4.size() != 0) ? q4.pop_front() : -1;
            end else begin
                chk({tag, " beat_expected"}, int'(q0.size() != 0), 1);
                exp = (q0.size() != 0) ? q0.pop_front() : -1;
            end
            chk({tag, " beat_kind_index"}, got, exp);
        end
    endtask

    task automatic run_seq(input vec_t v);
        int d0;
        int act_hi;
        int nt;
        d0     = v.done - 4;
        act_hi = v.done - 5;
        q4.delete();
        q0.delete();
        @(posedge clk); #1;
        start4 = 1'b1; start0 = 1'b1;
        mat_len = 10'(v.ml); run_len = 16'(v.rl);
        get_valid = 1'b1; stall = 1'b0;
        for (int i = 0; i < v.ml; i++) begin q4.push_back(i); q0.push_back(i); end
        for (int i = 0; i < v.rl; i++) begin q4.push_back((1 << 16) | i); q0.push_back((1 << 16) | i); end
        for (int t = 0; t <= v.done + 1; t++) begin
            @(negedge clk);
            check_dut(4, t, v.done, act_hi, stall, gr4, matw4, run4, mwe4, addr4, gv4, idx4, busy4, done4);
            check_dut(0, t, d0, act_hi, stall, gr0, matw0, run0, mwe0, addr0, gv0, idx0, busy0, done0);
`ifdef GET_SCHED_PERF_EN
            if (t == v.done + 1) begin
                chk("dut4 stall_cyc", int'(sc4), v.perf);
                chk("dut0 stall_cyc", int'(sc0), v.perf);
            end
`endif
            @(posedge clk); #1;
            nt = t + 1;
            stall     = (nt >= v.slo) && (nt <= v.shi);
            get_valid = !((nt >= v.vlo) && (nt <= v.vhi));
            start4    = (v.noise != 0) && (nt <= v.done);
            start0    = (v.noise != 0) && (nt <= d0);
            if (v.noise != 0) begin
                mat_len = 10'($urandom_range(0, 1023));
                run_len = 16'($urandom_range(0, 65535));
            end
        end
        chk("dut4 beats_left", q4.size(), 0);
        chk("dut0 beats_left", q0.size(), 0);
        start4 = 1'b0; start0 = 1'b0; stall = 1'b0; get_valid = 1'b1;
        $display("seq ml=%0d rl=%0d stall=%0d..%0d vlow=%0d..%0d noise=%0d done@%0d checks=%0d fails=%0d",
                 v.ml, v.rl, v.slo, v.shi, v.vlo, v.vhi, v.noise, v.done, n_chk, n_fail);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " get_ready"}, int'(gr4 | gr0), 0);
        chk({tag, " matw"},      int'(matw4 | matw0), 0);
        chk({tag, " run"},       int'(run4 | run0), 0);
        chk({tag, " mat_we"},    int'(mwe4 | mwe0), 0);
        chk({tag, " get_v"},     int'(gv4 | gv0), 0);
        chk({tag, " mat_addr"},  int'(addr4 | addr0), 0);
        chk({tag, " run_idx"},   int'(idx4 | idx0), 0);
        chk({tag, " busy"},      int'(busy4 | busy0), 0);
        chk({tag, " done"},      int'(done4 | done0), 0);
    endtask

    initial begin
        //        ml rl slo shi vlo vhi noise done perf
        tv[0] = '{3, 5, 0, -1, 0, -1, 0, 13, 0};   // basic flow
        tv[1] = '{0, 2, 0, -1, 0, -1, 0,  7, 0};   // no matrix phase
        tv[2] = '{2, 2, 2,  4, 0, -1, 0, 12, 3};   // stall mid matrix write
        tv[3] = '{2, 3, 0, -1, 0, -1, 1, 10, 0};   // start/lengths noise while busy
        tv[4] = '{0, 0, 0, -1, 0, -1, 0,  5, 0};   // empty sequence
        tv[5] = '{4, 3, 6,  6, 3,  4, 0, 15, 3};   // valid gap plus a stall
        tv[6] = '{1, 0, 0, -1, 0, -1, 0,  6, 0};   // matrix only
        tv[7] = '{1, 1, 1,  2, 0, -1, 0,  9, 2};   // stall from the first cycle
        tv[8] = '{1, 1, 3,  6, 0, -1, 0,  7, 0};   // stall during drain is ignored

        rst_n = 1'b0; start4 = 1'b0; start0 = 1'b0;
        mat_len = '0; run_len = '0; get_valid = 1'b1; stall = 1'b0;
        #12;
        check_idle_outputs("reset");
`ifdef GET_SCHED_PERF_EN
        chk("reset stall_cyc", int'(sc4 | sc0), 0);
`endif
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_seq(tv[i]);

        // Reset while in RUN at run_idx 2, then a clean restart.
        @(posedge clk); #1;
        start4 = 1'b1; start0 = 1'b1; mat_len = 10'd2; run_len = 16'd5;
        @(posedge clk); #1;
        start4 = 1'b0; start0 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre-reset dut4 run_idx", int'(idx4), 2);
        chk("pre-reset dut4 get_v", int'(gv4), 1);
        chk("pre-reset dut0 run_idx", int'(idx0), 2);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun-reset");
        #2 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset c=%0d done", c), int'(done4 | done0), 0);
            chk($sformatf("post-reset c=%0d busy", c), int'(busy4 | busy0), 0);
        end
        $display("seq mid-run reset checks=%0d fails=%0d", n_chk, n_fail);
        run_seq(tv[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
